matvec_tile_ctrl: RTL

Sequencer that computes y = A·x for an N×N signed 8-bit matrix and N-element signed 8-bit vector by reusing a single 2×2-by-2×1 tile multiply-add datapath. The host streams 2×2 matrix tiles, each paired with its 2-element vector slice. The block accumulates each tile-row and emits one (y1, y2) result pair per tile-row over a valid/ready output channel. It sits between the layer-level scheduler (start/done) and the tile datapath inside the neural-network accelerator core.

---
 rtl/matvec_pkg.sv | 23 ++
 rtl/tile_mac_pair.sv | 61 ++++++
 rtl/matvec_tile_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/matvec_pkg.sv
// Shared types and width helpers for the tiled matrix-vector sequencer.
package matvec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;
  localparam int SUM_W  = 17;

  // Minimum accumulator width that holds T tile-row sums exactly.
  function automatic int acc_width(input int n);
    return SUM_W + $clog2(n / 2);
  endfunction

  function automatic int cnt_width(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/tile_mac_pair.sv
// 2x2 tile times 2x1 slice multiply-add into two registered row accumulators.
module tile_mac_pair
  import matvec_pkg::*;
#(
  parameter int ACC_W = 19
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_W-1:0]        i_a11,
  input  logic [DATA_W-1:0]        i_a12,
  input  logic [DATA_W-1:0]        i_a21,
  input  logic [DATA_W-1:0]        i_a22,
  input  logic [DATA_W-1:0]        i_x1,
  input  logic [DATA_W-1:0]        i_x2,
  input  logic                     i_acc_clr,
  input  logic                     i_acc_en,
  output logic [ACC_W-1:0]         o_acc1_nxt,
  output logic [ACC_W-1:0]         o_acc2_nxt
);

  logic signed [PROD_W-1:0] w_p11;
  logic signed [PROD_W-1:0] w_p12;
  logic signed [PROD_W-1:0] w_p21;
  logic signed [PROD_W-1:0] w_p22;
  logic signed [SUM_W-1:0]  w_s1;
  logic signed [SUM_W-1:0]  w_s2;
  logic signed [ACC_W-1:0]  w_nxt1;
  logic signed [ACC_W-1:0]  w_nxt2;
  logic signed [ACC_W-1:0]  r_acc1;
  logic signed [ACC_W-1:0]  r_acc2;

  // Operands are widened before multiplying so the full signed product is kept.
  assign w_p11 = PROD_W'($signed(i_a11)) * PROD_W'($signed(i_x1));
  assign w_p12 = PROD_W'($signed(i_a12)) * PROD_W'($signed(i_x2));
  assign w_p21 = PROD_W'($signed(i_a21)) * PROD_W'($signed(i_x1));
  assign w_p22 = PROD_W'($signed(i_a22)) * PROD_W'($signed(i_x2));

  assign w_s1 = SUM_W'(w_p11) + SUM_W'(w_p12);
  assign w_s2 = SUM_W'(w_p21) + SUM_W'(w_p22);

  assign w_nxt1 = r_acc1 + ACC_W'(w_s1);
  assign w_nxt2 = r_acc2 + ACC_W'(w_s2);

  assign o_acc1_nxt = w_nxt1;
  assign o_acc2_nxt = w_nxt2;

  // Accumulator registers: clear has priority over accumulate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
    end else if (i_acc_clr) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
    end else if (i_acc_en) begin
      r_acc1 <= w_nxt1;
      r_acc2 <= w_nxt2;
    end
  end

endmodule

// File: rtl/matvec_tile_ctrl.sv
// Sequences N/2 x N/2 tiles through one tile_mac_pair and emits one (y1, y2)
// pair per tile-row over a valid/ready channel.
module matvec_tile_ctrl
  import matvec_pkg::*;
#(
  parameter int N     = 8,
  parameter int ACC_W = 19
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [7:0]                    i_a11,
  input  logic [7:0]                    i_a12,
  input  logic [7:0]                    i_a21,
  input  logic [7:0]                    i_a22,
  input  logic [7:0]                    i_x1,
  input  logic [7:0]                    i_x2,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [ACC_W-1:0]              o_y1,
  output logic [ACC_W-1:0]              o_y2,
  output logic [cnt_width(N/2)-1:0]     o_out_row
);

  localparam int T     = N / 2;
  localparam int CNT_W = cnt_width(T);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(T - 1);

  generate
    if ((N < 2) || ((N % 2) != 0) || (ACC_W < acc_width(N))) begin : g_param_check
      $error("matvec_tile_ctrl: N must be even and >= 2, and ACC_W >= acc_width(N)");
    end
  endgenerate

  state_t           r_state;
  logic [CNT_W-1:0] r_col_cnt;
  logic [CNT_W-1:0] r_row_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_y1;
  logic [ACC_W-1:0] r_y2;
  logic [CNT_W-1:0] r_out_row;

  logic             w_start_ok;
  logic             w_tile_hs;
  logic             w_out_hs;
  logic             w_acc_clr;
  logic             w_acc_en;
  logic [ACC_W-1:0] w_acc1_nxt;
  logic [ACC_W-1:0] w_acc2_nxt;

  // A start coinciding with the done pulse is dropped; it is honoured a cycle later.
  assign w_start_ok = (r_state == ST_IDLE) && i_start && !r_done;
  assign w_tile_hs  = (r_state == ST_RUN) && i_in_valid && r_in_ready;
  assign w_out_hs   = (r_state == ST_OUT) && r_out_valid && i_out_ready;
  assign w_acc_clr  = w_start_ok || w_out_hs;
  assign w_acc_en   = w_tile_hs;

  tile_mac_pair #(
    .ACC_W (ACC_W)
  ) u_mac (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_a11      (i_a11),
    .i_a12      (i_a12),
    .i_a21      (i_a21),
    .i_a22      (i_a22),
    .i_x1       (i_x1),
    .i_x2       (i_x2),
    .i_acc_clr  (w_acc_clr),
    .i_acc_en   (w_acc_en),
    .o_acc1_nxt (w_acc1_nxt),
    .o_acc2_nxt (w_acc2_nxt)
  );

  // Controller FSM with counters and registered handshake outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_out_row   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state    <= ST_RUN;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_tile_hs) begin
            if (r_col_cnt == LAST_IDX) begin
              r_y1        <= w_acc1_nxt;
              r_y2        <= w_acc2_nxt;
              r_out_row   <= r_row_cnt;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= ST_OUT;
            end else begin
              r_col_cnt <= r_col_cnt + CNT_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            if (r_row_cnt == LAST_IDX) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_row_cnt  <= r_row_cnt + CNT_W'(1);
              r_col_cnt  <= '0;
              r_in_ready <= 1'b1;
              r_state    <= ST_RUN;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_y1        = r_y1;
  assign o_y2        = r_y2;
  assign o_out_row   = r_out_row;

endmodule
